// File: rtl/dsp_pkg.sv
// Shared types and width helpers for the pre-add multiply-accumulate datapath.
package dsp_pkg;

    // Per-beat pre-adder mode, driven from i_sub.
    typedef enum logic {
        PREADD_ADD = 1'b0,
        PREADD_SUB = 1'b1
    } preadd_mode_e;

    // Group tracking: IDLE means the next valid beat opens a new group.
    typedef enum logic {
        GRP_IDLE  = 1'b0,
        GRP_ACCUM = 1'b1
    } grp_state_e;

    // Exact signed product width of (a +/- b) * c.
    function automatic int prod_width(input int value_width);
        return 2 * value_width + 1;
    endfunction

    // Accumulator width: product plus guard bits.
    function automatic int acc_width(input int value_width, input int acc_guard);
        return prod_width(value_width) + acc_guard;
    endfunction

endpackage

// File: rtl/dsp_preadd_mul.sv
// Stages 1-2: pre-adder/subtractor then exact signed multiply, with valid/last
// sideband carried alongside. Every register freezes when i_ce is low.
module dsp_preadd_mul
    import dsp_pkg::*;
#(
    parameter int VALUE_WIDTH = 32
) (
    input  logic                                  i_clk,
    input  logic                                  i_areset,
    input  logic                                  i_ce,
    input  logic                                  i_valid,
    input  logic [VALUE_WIDTH-1:0]                i_presub_a,
    input  logic [VALUE_WIDTH-1:0]                i_presub_b,
    input  logic [VALUE_WIDTH-1:0]                i_mul,
    input  logic                                  i_sub,
    input  logic                                  i_last,
    output logic [prod_width(VALUE_WIDTH)-1:0]    o_prod,
    output logic                                  o_valid,
    output logic                                  o_last
);

    localparam int PW = prod_width(VALUE_WIDTH);

    preadd_mode_e                w_mode;
    logic signed [VALUE_WIDTH:0] w_a_ext;
    logic signed [VALUE_WIDTH:0] w_b_ext;
    logic signed [VALUE_WIDTH:0] w_pre;

    logic signed [VALUE_WIDTH:0]   r_pre;
    logic signed [VALUE_WIDTH-1:0] r_c;
    logic                          r_vld1;
    logic                          r_last1;
    logic signed [PW-1:0]          r_prod;
    logic                          r_vld2;
    logic                          r_last2;

    // One extra bit on the pre-adder makes a +/- b exact.
    assign w_mode  = preadd_mode_e'(i_sub);
    assign w_a_ext = {i_presub_a[VALUE_WIDTH-1], i_presub_a};
    assign w_b_ext = {i_presub_b[VALUE_WIDTH-1], i_presub_b};
    assign w_pre   = (w_mode == PREADD_SUB) ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

    // Stage 1 pre-add and stage 2 multiply; last is only meaningful on valid beats.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_pre   <= '0;
            r_c     <= '0;
            r_vld1  <= 1'b0;
            r_last1 <= 1'b0;
            r_prod  <= '0;
            r_vld2  <= 1'b0;
            r_last2 <= 1'b0;
        end else if (i_ce) begin
            r_pre   <= w_pre;
            r_c     <= i_mul;
            r_vld1  <= i_valid;
            r_last1 <= i_valid & i_last;
            r_prod  <= r_pre * r_c;
            r_vld2  <= r_vld1;
            r_last2 <= r_last1;
        end
    end

    assign o_prod  = r_prod;
    assign o_valid = r_vld2;
    assign o_last  = r_last2;

endmodule

// File: rtl/dsp_preadd_mac.sv
// Pre-add multiply-accumulate: sums (a +/- b) * c over a group of beats ended
// by i_last and emits one signed result per group with a sticky overflow flag.
module dsp_preadd_mac
    import dsp_pkg::*;
#(
    parameter int VALUE_WIDTH = 32,
    parameter int ACC_GUARD   = 8,
    parameter int SATURATE    = 1
) (
    input  logic                                         i_clk,
    input  logic                                         i_areset,
    input  logic                                         i_ce,
    input  logic                                         i_valid,
    input  logic [VALUE_WIDTH-1:0]                       i_presub_a,
    input  logic [VALUE_WIDTH-1:0]                       i_presub_b,
    input  logic [VALUE_WIDTH-1:0]                       i_mul,
    input  logic                                         i_sub,
    input  logic                                         i_last,
    output logic [acc_width(VALUE_WIDTH, ACC_GUARD)-1:0] o_out,
    output logic                                         o_valid,
    output logic                                         o_overflow
);

    localparam int PW = prod_width(VALUE_WIDTH);
    localparam int AW = acc_width(VALUE_WIDTH, ACC_GUARD);
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    logic signed [PW-1:0] w_prod;
    logic                 w_beat;
    logic                 w_lastb;

    grp_state_e r_state;
    grp_state_e w_state_nxt;
    logic       w_first;
    logic       w_emit;

    logic signed [AW-1:0] w_prod_ext;
    logic signed [AW-1:0] w_base;
    logic signed [AW-1:0] w_sum;
    logic signed [AW-1:0] w_acc_next;
    logic                 w_ovf;

    logic [AW-1:0] r_acc;
    logic          r_sticky;
    logic [AW-1:0] r_res;
    logic          r_res_ovf;
    logic          r_res_vld;
    logic [AW-1:0] r_out;
    logic          r_out_ovf;
    logic          r_out_vld;

    dsp_preadd_mul #(
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_mul (
        .i_clk      (i_clk),
        .i_areset   (i_areset),
        .i_ce       (i_ce),
        .i_valid    (i_valid),
        .i_presub_a (i_presub_a),
        .i_presub_b (i_presub_b),
        .i_mul      (i_mul),
        .i_sub      (i_sub),
        .i_last     (i_last),
        .o_prod     (w_prod),
        .o_valid    (w_beat),
        .o_last     (w_lastb)
    );

    // Group state register; only valid beats on enabled cycles move it.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset)  r_state <= GRP_IDLE;
        else if (i_ce) r_state <= w_state_nxt;
    end

    // Next state: a last beat always closes the group, any other beat keeps it open.
    always_comb begin
        w_state_nxt = r_state;
        if (w_beat) w_state_nxt = w_lastb ? GRP_IDLE : GRP_ACCUM;
    end

    // State decode: IDLE means start from zero; a valid last beat emits.
    always_comb begin
        w_first = (r_state == GRP_IDLE);
        w_emit  = w_beat & w_lastb;
    end

    // Accumulate with signed overflow detection and optional clamp.
    always_comb begin
        w_prod_ext = AW'(w_prod);
        w_base     = w_first ? '0 : $signed(r_acc);
        w_sum      = w_base + w_prod_ext;
        w_ovf      = (w_base[AW-1] == w_prod_ext[AW-1]) && (w_sum[AW-1] != w_base[AW-1]);
        w_acc_next = w_sum;
        if (w_ovf && (SATURATE != 0)) w_acc_next = w_base[AW-1] ? $signed(ACC_MIN) : $signed(ACC_MAX);
    end

    // Stage 3: accumulator, sticky overflow and captured group result.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_acc     <= '0;
            r_sticky  <= 1'b0;
            r_res     <= '0;
            r_res_ovf <= 1'b0;
            r_res_vld <= 1'b0;
        end else if (i_ce) begin
            r_res_vld <= w_emit;
            if (w_beat) begin
                r_acc    <= w_acc_next;
                r_sticky <= w_emit ? 1'b0 : (r_sticky | w_ovf);
            end
            if (w_emit) begin
                r_res     <= w_acc_next;
                r_res_ovf <= r_sticky | w_ovf;
            end
        end
    end

    // Output register keeps the accumulator feedback path off the output pins.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_out     <= '0;
            r_out_ovf <= 1'b0;
            r_out_vld <= 1'b0;
        end else if (i_ce) begin
            r_out_vld <= r_res_vld;
            if (r_res_vld) begin
                r_out     <= r_res;
                r_out_ovf <= r_res_ovf;
            end
        end
    end

    assign o_out      = r_out;
    assign o_valid    = r_out_vld;
    assign o_overflow = r_out_ovf;

endmodule

// File: tb/tb_dsp_preadd_mac.sv
// Scoreboard bench: one wide instance (32-bit, 8 guard bits, saturating) and two
// narrow instances (8-bit, no guard) differing only in saturate vs wrap.
module tb_dsp_preadd_mac;

    typedef struct {
        logic [72:0] out;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    always #5 clk = ~clk;

    logic        m_valid, m_sub, m_last;
    logic [31:0] m_a, m_b, m_c;
    logic [72:0] m_out;
    logic        m_ovalid, m_ovf;

    logic        s_valid, s_sub, s_last;
    logic [7:0]  s_a, s_b, s_c;
    logic [16:0] sat_out, wrp_out;
    logic        sat_ovalid, sat_ovf, wrp_ovalid, wrp_ovf;

    dsp_preadd_mac #(.VALUE_WIDTH(32), .ACC_GUARD(8), .SATURATE(1)) u_main (
        .i_clk(clk), .i_areset(rst), .i_ce(ce), .i_valid(m_valid),
        .i_presub_a(m_a), .i_presub_b(m_b), .i_mul(m_c), .i_sub(m_sub), .i_last(m_last),
        .o_out(m_out), .o_valid(m_ovalid), .o_overflow(m_ovf));

    dsp_preadd_mac #(.VALUE_WIDTH(8), .ACC_GUARD(0), .SATURATE(1)) u_sat (
        .i_clk(clk), .i_areset(rst), .i_ce(ce), .i_valid(s_valid),
        .i_presub_a(s_a), .i_presub_b(s_b), .i_mul(s_c), .i_sub(s_sub), .i_last(s_last),
        .o_out(sat_out), .o_valid(sat_ovalid), .o_overflow(sat_ovf));

    dsp_preadd_mac #(.VALUE_WIDTH(8), .ACC_GUARD(0), .SATURATE(0)) u_wrp (
        .i_clk(clk), .i_areset(rst), .i_ce(ce), .i_valid(s_valid),
        .i_presub_a(s_a), .i_presub_b(s_b), .i_mul(s_c), .i_sub(s_sub), .i_last(s_last),
        .o_out(wrp_out), .o_valid(wrp_ovalid), .o_overflow(wrp_ovf));

    int n_cmp = 0;
    int n_bad = 0;
    int en_cnt = 0;

    exp_t q_m[$];
    exp_t q_s[$];
    exp_t q_w[$];
    exp_t em, es, ew;

    // Reference accumulators.
    logic signed [72:0] acc_m = '0;
    logic signed [72:0] acc_s = '0;
    logic signed [72:0] acc_w = '0;
    logic               of_s = 1'b0;
    logic               of_w = 1'b0;
    localparam logic signed [72:0] SMAX = 73'sd65535;
    localparam logic signed [72:0] SMIN = -73'sd65536;

    task automatic chk(input string tag, input logic [72:0] act, input logic [72:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Count enabled, non-reset edges; latency is measured in these.
    always @(posedge clk) if (ce && !rst) en_cnt <= en_cnt + 1;

    // Pop and compare whenever a result is presented on an enabled cycle.
    always @(negedge clk) begin
        if (!rst && ce) begin
            if (m_ovalid) begin
                if (q_m.size() == 0) chk("main_unexpected", 73'(m_ovalid), 73'd0);
                else begin
                    em = q_m.pop_front();
                    chk("main_out", m_out, em.out);
                    chk("main_ovf", 73'(m_ovf), 73'(em.ovf));
                    chk("main_lat", 73'(en_cnt), 73'(em.cyc));
                end
            end
            if (sat_ovalid) begin
                if (q_s.size() == 0) chk("sat_unexpected", 73'(sat_ovalid), 73'd0);
                else begin
                    es = q_s.pop_front();
                    chk("sat_out", {{56{sat_out[16]}}, sat_out}, es.out);
                    chk("sat_ovf", 73'(sat_ovf), 73'(es.ovf));
                    chk("sat_lat", 73'(en_cnt), 73'(es.cyc));
                end
            end
            if (wrp_ovalid) begin
                if (q_w.size() == 0) chk("wrap_unexpected", 73'(wrp_ovalid), 73'd0);
                else begin
                    ew = q_w.pop_front();
                    chk("wrap_out", {{56{wrp_out[16]}}, wrp_out}, ew.out);
                    chk("wrap_ovf", 73'(wrp_ovf), 73'(ew.ovf));
                    chk("wrap_lat", 73'(en_cnt), 73'(ew.cyc));
                end
            end
        end
    end

    // One enabled cycle of stimulus; sel 0 drives the wide DUT, 1 the narrow pair.
    task automatic beat(input int sel, input logic v, input int a, input int b, input int c,
                        input logic sub, input logic last);
        logic signed [72:0] ta, tb, tc, term, sum;
        exp_t e;
        @(posedge clk); #1;
        ce      = 1'b1;
        m_valid = (sel == 0) && v;
        s_valid = (sel == 1) && v;
        m_a = a; m_b = b; m_c = c; m_sub = sub; m_last = last;
        s_a = a[7:0]; s_b = b[7:0]; s_c = c[7:0]; s_sub = sub; s_last = last;
        if (v) begin
            ta = a; tb = b; tc = c;
            term = (sub ? (ta - tb) : (ta + tb)) * tc;
            if (sel == 0) begin
                acc_m = acc_m + term;
                if (last) begin
                    e.out = acc_m; e.ovf = 1'b0; e.cyc = en_cnt + 4;
                    q_m.push_back(e);
                    acc_m = '0;
                end
            end else begin
                sum = acc_s + term;
                if (sum > SMAX) begin acc_s = SMAX; of_s = 1'b1; end
                else if (sum < SMIN) begin acc_s = SMIN; of_s = 1'b1; end
                else acc_s = sum;
                sum = acc_w + term;
                if (sum > SMAX || sum < SMIN) of_w = 1'b1;
                acc_w = {{56{sum[16]}}, sum[16:0]};
                if (last) begin
                    e.out = acc_s; e.ovf = of_s; e.cyc = en_cnt + 4;
                    q_s.push_back(e);
                    e.out = acc_w; e.ovf = of_w;
                    q_w.push_back(e);
                    acc_s = '0; acc_w = '0; of_s = 1'b0; of_w = 1'b0;
                end
            end
        end
    endtask

    // Bubbles carry junk operands and a set last flag, which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(0, 1'b0, 99, -7, 13, 1'b1, 1'b1);
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ce = 1'b0;
            m_valid = 1'b1; m_last = 1'b1;
        end
    endtask

    initial begin
        int glen;
        rst = 1'b1; ce = 1'b1;
        m_valid = 0; m_sub = 0; m_last = 0; m_a = 0; m_b = 0; m_c = 0;
        s_valid = 0; s_sub = 0; s_last = 0; s_a = 0; s_b = 0; s_c = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out", m_out, 73'd0);
        chk("rst_valid", 73'(m_ovalid), 73'd0);
        chk("rst_ovf", 73'(m_ovf), 73'd0);
        chk("rst_sat_valid", 73'(sat_ovalid), 73'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Single-beat groups.
        beat(0, 1, 3, 4, 5, 1, 1);
        beat(0, 1, 5, 4, 5, 1, 1);
        idle(5);

        // Three-beat group: 20 - 12 - 30 = -22.
        beat(0, 1, 2, 3, 4, 0, 0);
        beat(0, 1, 7, 1, -2, 1, 0);
        beat(0, 1, -5, 5, 3, 1, 1);
        idle(5);

        // Same group with bubbles and a 4-cycle stall mid-group.
        beat(0, 1, 2, 3, 4, 0, 0);
        idle(2);
        beat(0, 1, 7, 1, -2, 1, 0);
        stall(4);
        idle(1);
        beat(0, 1, -5, 5, 3, 1, 1);
        idle(6);

        // Random back-to-back groups of 1..4 beats.
        for (int g = 0; g < 20; g++) begin
            glen = $urandom_range(1, 4);
            for (int k = 0; k < glen; k++) begin
                beat(0, 1, int'($urandom), int'($urandom), int'($urandom),
                     1'($urandom_range(0, 1)), k == glen - 1);
                if ($urandom_range(0, 5) == 0) idle(1);
            end
        end
        idle(6);

        // Narrow overflow: 3 x 32385 exceeds 17-bit range.
        beat(1, 1, 127, -128, 127, 1, 0);
        beat(1, 1, 127, -128, 127, 1, 0);
        beat(1, 1, 127, -128, 127, 1, 1);
        beat(1, 1, 1, 1, 1, 0, 1);
        idle(6);

        // Reset mid-group: discard two in-flight beats.
        beat(0, 1, 1000, 20, 3, 0, 0);
        beat(0, 1, 1000, 20, 3, 0, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        m_valid = 1'b0;
        #1;
        chk("midrst_out", m_out, 73'd0);
        chk("midrst_valid", 73'(m_ovalid), 73'd0);
        chk("midrst_ovf", 73'(m_ovf), 73'd0);
        q_m.delete(); q_s.delete(); q_w.delete();
        acc_m = '0; acc_s = '0; acc_w = '0; of_s = 1'b0; of_w = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        beat(0, 1, 1, 1, 1, 0, 1);
        idle(8);

        chk("drain_main", 73'(q_m.size()), 73'd0);
        chk("drain_sat", 73'(q_s.size()), 73'd0);
        chk("drain_wrap", 73'(q_w.size()), 73'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
